// File: rtl/cnn_conv1_acc_relu_if.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_conv1_acc_relu_if
//  Purpose  : Product-in / result-out handshake bundle for the conv1
//             accumulate + ReLU stage.
//  Revision : 1.0  initial release
// ============================================================================
interface cnn_conv1_acc_relu_if #(
  parameter int PROD_W = 23,
  parameter int BIAS_W = 14,
  parameter int OUT_W  = 14
);
  logic [PROD_W-1:0] prod_din;
  logic              prod_vld;
  logic              prod_rdy;
  logic [BIAS_W-1:0] bias_din;
  logic [OUT_W-1:0]  out_dout;
  logic              out_vld;
  logic              out_rdy;
  logic              busy;

  // Upstream multiplier / downstream consumer side
  modport master (
    output prod_din, prod_vld, bias_din, out_rdy,
    input  prod_rdy, out_dout, out_vld, busy
  );

  // Accumulator side
  modport slave (
    input  prod_din, prod_vld, bias_din, out_rdy,
    output prod_rdy, out_dout, out_vld, busy
  );
endinterface
`default_nettype wire

// File: rtl/cnn_conv1_acc_relu.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_conv1_acc_relu
//  Purpose  : Accumulates one kernel window of signed products plus a bias,
//             rounds half-up, applies optional ReLU, saturates to OUT_W and
//             hands the result downstream on a valid/ready port.
//  Revision : 1.0  initial release
// ============================================================================
module cnn_conv1_acc_relu #(
  parameter int NUM_TERMS  = 25,
  parameter int PROD_W     = 23,
  parameter int BIAS_W     = 14,
  parameter int OUT_W      = 14,
  parameter int ACC_W      = 32,
  parameter int FRAC_SHIFT = 8,
  parameter int BIAS_SHIFT = 8,
  parameter int RELU_EN    = 1
) (
  input  wire logic           ap_clk,
  input  wire logic           ap_rst,
  cnn_conv1_acc_relu_if.slave bus
);

  localparam int c_CNT_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(NUM_TERMS - 1);
  localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

  // Half an output LSB at accumulator scale, for round-half-up
  localparam logic signed [ACC_W-1:0] c_HALF = ACC_W'(1) << (FRAC_SHIFT - 1);
  // Output range limits, sign-extended to accumulator width
  localparam logic signed [ACC_W-1:0] c_MAX =
    {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_MIN =
    {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_FINAL = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [c_CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [OUT_W-1:0]          dout_q, dout_d;
  logic                      vld_q, vld_d;

  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   bias_ext;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   rnd_val;
  logic signed [ACC_W-1:0]   relu_val;
  logic signed [ACC_W-1:0]   sat_val;
  logic                      accept;

  assign prod_ext = {{(ACC_W-PROD_W){bus.prod_din[PROD_W-1]}}, bus.prod_din};
  assign bias_ext = {{(ACC_W-BIAS_W){bus.bias_din[BIAS_W-1]}}, bus.bias_din};
  assign accept   = bus.prod_vld && (state_q == ST_ACC);

  // Round half up, clamp negatives when ReLU is on, then saturate
  always_comb begin
    rnd_sum  = acc_q + c_HALF;
    rnd_val  = rnd_sum >>> FRAC_SHIFT;
    relu_val = ((RELU_EN != 0) && (rnd_val < 0)) ? '0 : rnd_val;
    if (relu_val > c_MAX) begin
      sat_val = c_MAX;
    end else if (relu_val < c_MIN) begin
      sat_val = c_MIN;
    end else begin
      sat_val = relu_val;
    end
  end

  // Next-state logic: accumulate window, finalise once, hold until taken
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    dout_d  = dout_q;
    vld_d   = vld_q;
    case (state_q)
      ST_ACC: begin
        if (accept) begin
          // Bias is only looked at on the first term of a window
          if (cnt_q == '0) begin
            acc_d = (bias_ext <<< BIAS_SHIFT) + prod_ext;
          end else begin
            acc_d = acc_q + prod_ext;
          end
          if (cnt_q == c_LAST) begin
            cnt_d   = '0;
            state_d = ST_FINAL;
          end else begin
            cnt_d = cnt_q + c_ONE;
          end
        end
      end
      ST_FINAL: begin
        dout_d  = sat_val[OUT_W-1:0];
        vld_d   = 1'b1;
        state_d = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_rdy) begin
          vld_d   = 1'b0;
          state_d = ST_ACC;
        end
      end
      default: begin
        state_d = ST_ACC;
      end
    endcase
  end

  // State register with synchronous reset discarding any partial window
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q <= ST_ACC;
      cnt_q   <= '0;
      acc_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
    end
  end

  assign bus.prod_rdy = (state_q == ST_ACC);
  assign bus.out_dout = dout_q;
  assign bus.out_vld  = vld_q;
  assign bus.busy     = (cnt_q != '0) || (state_q != ST_ACC);

endmodule
`default_nettype wire
